// File: rtl/iq_modulation.sv
// rtl/iq_modulation.sv - fs/4 I/Q upconverter with a 2-deep input FIFO, one IF sample per DAC tick
// Optional IQ_MOD_SAT_EN: negating the most negative sample saturates instead of wrapping.
module iq_modulation #(
  parameter int DAC_DIV = 5,
  parameter int W       = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] I_BB,
  input  logic signed [W-1:0] Q_BB,
  input  logic                BB_valid,
  output logic                BB_ready,
  output logic signed [W-1:0] I_IF,
  output logic signed [W-1:0] Q_IF,
  output logic                DAC_rdy,
  output logic [1:0]          cosine_out,
  output logic [1:0]          sine_out,
  output logic                underflow
);
  localparam int CW = $clog2(DAC_DIV);
  localparam logic [CW-1:0] LAST = CW'(DAC_DIV - 1);

  function automatic logic signed [W-1:0] neg(input logic signed [W-1:0] x);
`ifdef IQ_MOD_SAT_EN
    if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
`endif
    return -x;
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          phase_q, phase_d;
  logic [1:0]          count_q, count_d;
  logic [2*W-1:0]      slot0_q, slot0_d, slot1_q, slot1_d;
  logic signed [W-1:0] i_if_q, i_if_d, q_if_q, q_if_d;
  logic                dac_rdy_q, dac_rdy_d;
  logic                underflow_q, underflow_d;
  logic [1:0]          cos_q, cos_d, sin_q, sin_d;

  logic                tick, push, pop;
  logic [2*W-1:0]      head;
  logic signed [W-1:0] head_i, head_q, mix_i, mix_q;
  logic [1:0]          lo_cos, lo_sin;

  assign BB_ready = !reset && (count_q != 2'd2);
  assign tick     = (cnt_q == LAST);
  assign push     = BB_valid && BB_ready;
  // An empty FIFO hands the incoming sample straight to a coinciding tick.
  assign head     = (count_q == 2'd0) ? {I_BB, Q_BB} : slot0_q;
  assign pop      = tick && ((count_q != 2'd0) || push);
  assign head_i   = head[2*W-1:W];
  assign head_q   = head[W-1:0];

  always_comb begin
    lo_cos = 2'b01;
    lo_sin = 2'b00;
    mix_i  = head_i;
    mix_q  = head_q;
    case (phase_q)
      2'd1: begin lo_cos = 2'b00; lo_sin = 2'b01; mix_i = neg(head_q); mix_q = head_i;       end
      2'd2: begin lo_cos = 2'b11;                 mix_i = neg(head_i); mix_q = neg(head_q);  end
      2'd3: begin lo_cos = 2'b00; lo_sin = 2'b11; mix_i = head_q;      mix_q = neg(head_i);  end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    phase_d     = phase_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    i_if_d      = i_if_q;
    q_if_d      = q_if_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    underflow_d = underflow_q;
    dac_rdy_d   = tick;

    if (pop) slot0_d = slot1_q;
    if (push) begin
      if (count_q == 2'd1 && !pop)     slot1_d = {I_BB, Q_BB};
      else if (count_q == 2'd1 || !pop) slot0_d = {I_BB, Q_BB};
    end

    // The LO advances on every tick so the carrier stays coherent across gaps.
    if (tick) begin
      phase_d = phase_q + 2'd1;
      cos_d   = lo_cos;
      sin_d   = lo_sin;
      if (pop) begin
        i_if_d = mix_i;
        q_if_d = mix_q;
      end else begin
        i_if_d      = '0;
        q_if_d      = '0;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      count_q     <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      i_if_q      <= '0;
      q_if_q      <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      underflow_q <= 1'b0;
      dac_rdy_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      i_if_q      <= i_if_d;
      q_if_q      <= q_if_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      underflow_q <= underflow_d;
      dac_rdy_q   <= dac_rdy_d;
    end
  end

  assign I_IF       = i_if_q;
  assign Q_IF       = q_if_q;
  assign DAC_rdy    = dac_rdy_q;
  assign cosine_out = cos_q;
  assign sine_out   = sin_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_iq_modulation.sv
// tb/tb_iq_modulation.sv - self-checking bench for iq_modulation (DAC_DIV=5, W=7)
module tb_iq_modulation;
  localparam int DIV = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [6:0] I_BB, Q_BB;
  logic              BB_valid;
  logic              BB_ready;
  logic signed [6:0] I_IF, Q_IF;
  logic              DAC_rdy;
  logic [1:0]        cosine_out, sine_out;
  logic              underflow;

  iq_modulation #(.DAC_DIV(DIV), .W(7)) dut (
    .clk(clk), .reset(reset), .I_BB(I_BB), .Q_BB(Q_BB), .BB_valid(BB_valid),
    .BB_ready(BB_ready), .I_IF(I_IF), .Q_IF(Q_IF), .DAC_rdy(DAC_rdy),
    .cosine_out(cosine_out), .sine_out(sine_out), .underflow(underflow)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic signed [6:0] i;
    logic signed [6:0] q;
    logic [1:0]        c;
    logic [1:0]        s;
    logic              uf;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  int   cyc;

  int   mq_i[$], mq_q[$];
  exp_t exp_q[$];
  int   m_cnt;
  logic [1:0] m_ph;
  logic m_rdy;
  exp_t m_out;

  int log_i[$], log_q[$], log_c[$], log_s[$], log_uf[$], log_t[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int i, input int q, input int ph, input logic empty, input logic uf_prev);
    int   c, s, ri, rq;
    exp_t e;
    c  = (ph == 0) ? 1 : ((ph == 2) ? -1 : 0);
    s  = (ph == 1) ? 1 : ((ph == 3) ? -1 : 0);
    ri = empty ? 0 : i * c - q * s;
    rq = empty ? 0 : i * s + q * c;
`ifdef IQ_MOD_SAT_EN
    if (ri > 63) ri = 63;
    if (rq > 63) rq = 63;
`endif
    e.i  = ri[6:0];
    e.q  = rq[6:0];
    e.c  = c[1:0];
    e.s  = s[1:0];
    e.uf = uf_prev | empty;
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference model: pushes the expected strobe contents onto exp_q at each tick.
  always @(posedge clk) begin
    if (reset) begin
      mq_i.delete(); mq_q.delete(); exp_q.delete();
      m_cnt <= 0; m_ph <= 2'd0; m_rdy <= 1'b0; m_out <= '0;
    end else begin
      m_rdy <= (m_cnt == DIV - 1);
      m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      if (BB_valid && mq_i.size() < 2) begin
        mq_i.push_back(int'(I_BB));
        mq_q.push_back(int'(Q_BB));
      end
      if (m_cnt == DIV - 1) begin
        m_ph <= m_ph + 2'd1;
        if (mq_i.size() > 0) begin
          exp_q.push_back(mk(mq_i[0], mq_q[0], int'(m_ph), 1'b0, m_out.uf));
          m_out <= mk(mq_i[0], mq_q[0], int'(m_ph), 1'b0, m_out.uf);
          void'(mq_i.pop_front());
          void'(mq_q.pop_front());
        end else begin
          exp_q.push_back(mk(0, 0, int'(m_ph), 1'b1, m_out.uf));
          m_out <= mk(0, 0, int'(m_ph), 1'b1, m_out.uf);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("dac_rdy", 32'(DAC_rdy), 32'(m_rdy));
      chk("bb_ready", 32'(BB_ready), 32'(!reset && mq_i.size() < 2));
      chk("hold_i", 32'(I_IF), 32'(m_out.i));
      chk("hold_q", 32'(Q_IF), 32'(m_out.q));
      chk("hold_cos", 32'(cosine_out), 32'(m_out.c));
      chk("hold_sin", 32'(sine_out), 32'(m_out.s));
      chk("hold_uf", 32'(underflow), 32'(m_out.uf));
      if (DAC_rdy) begin
        chk("sb_pending", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          chk("sb_i", 32'(I_IF), 32'(exp_q[0].i));
          chk("sb_q", 32'(Q_IF), 32'(exp_q[0].q));
          chk("sb_cos", 32'(cosine_out), 32'(exp_q[0].c));
          chk("sb_sin", 32'(sine_out), 32'(exp_q[0].s));
          void'(exp_q.pop_front());
        end
        log_i.push_back(int'(I_IF));
        log_q.push_back(int'(Q_IF));
        log_c.push_back(int'(cosine_out));
        log_s.push_back(int'(sine_out));
        log_uf.push_back(int'(underflow));
        log_t.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    log_i.delete(); log_q.delete(); log_c.delete();
    log_s.delete(); log_uf.delete(); log_t.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (log_i.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("strobe_count", 32'(log_i.size() >= n), 32'(1));
  endtask

  task automatic push(input int i, input int q);
    int k = 0;
    BB_valid = 1'b1;
    I_BB     = 7'(i);
    Q_BB     = 7'(q);
    while (!BB_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("push_accept", 32'(BB_ready), 32'(1));
    @(negedge clk);
    BB_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    int kk;
    int k;
    logic nxt;
    reset = 1'b1; BB_valid = 1'b0; I_BB = '0; Q_BB = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_i", 32'(I_IF), 0);
    chk("rst_q", 32'(Q_IF), 0);
    chk("rst_dac_rdy", 32'(DAC_rdy), 0);
    chk("rst_cos", 32'(cosine_out), 0);
    chk("rst_sin", 32'(sine_out), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_ready", 32'(BB_ready), 0);

    // Idle: strobes every 5 cycles with zero output and underflow
    reset = 1'b0;
    #1;
    clear_logs();
    wait_strobes(4, 60);
    chk("idle_t0", log_t[0], 5);
    chk("idle_t1", log_t[1], 10);
    chk("idle_t2", log_t[2], 15);
    chk("idle_t3", log_t[3], 20);
    chk("idle_i0", log_i[0], 0);
    chk("idle_q1", log_q[1], 0);
    chk("idle_uf0", log_uf[0], 1);
    chk("idle_cos0", log_c[0], 1);
    chk("idle_cos1", log_c[1], 0);
    chk("idle_cos2", log_c[2], 3);
    chk("idle_cos3", log_c[3], 0);
    chk("idle_sin1", log_s[1], 1);
    chk("idle_sin3", log_s[3], 3);

    // Continuous stream I=10, Q=-20
    do_reset();
    clear_logs();
    BB_valid = 1'b1; I_BB = 7'(10); Q_BB = 7'(-20);
    wait_strobes(5, 60);
    BB_valid = 1'b0;
    chk("str_i0", log_i[0], 10);  chk("str_q0", log_q[0], -20);
    chk("str_i1", log_i[1], 20);  chk("str_q1", log_q[1], 10);
    chk("str_i2", log_i[2], -10); chk("str_q2", log_q[2], 20);
    chk("str_i3", log_i[3], -20); chk("str_q3", log_q[3], -10);
    chk("str_i4", log_i[4], 10);  chk("str_q4", log_q[4], -20);
    chk("str_uf4", log_uf[4], 0);

    // Hold BB_valid with distinct samples: 2 accepted before first tick, then 1 per 5
    do_reset();
    clear_logs();
    kk = 1;
    BB_valid = 1'b1; I_BB = 7'(kk); Q_BB = 7'(kk + 1);
    for (int c = 0; c < 18; c++) begin
      if (cyc == 3) chk("hold_ready_full", 32'(BB_ready), 0);
      nxt = BB_ready;
      if (nxt) acc.push_back(cyc + 1);
      @(negedge clk);
      if (nxt) begin
        kk++;
        I_BB = 7'(kk); Q_BB = 7'(kk + 1);
      end
    end
    BB_valid = 1'b0;
    chk("acc_n", acc.size(), 5);
    chk("acc0", acc[0], 1);
    chk("acc1", acc[1], 2);
    chk("acc2", acc[2], 6);
    chk("acc3", acc[3], 11);
    chk("acc4", acc[4], 16);
    wait_strobes(4, 60);
    chk("ord_i0", log_i[0], 1);  chk("ord_q0", log_q[0], 2);
    chk("ord_i1", log_i[1], -3); chk("ord_q1", log_q[1], 2);
    chk("ord_i2", log_i[2], -3); chk("ord_q2", log_q[2], -4);
    chk("ord_i3", log_i[3], 5);  chk("ord_q3", log_q[3], -4);
    chk("ord_uf3", log_uf[3], 0);

    // Most negative input at p=2
    do_reset();
    clear_logs();
    push(5, 5);
    push(5, 5);
    push(-64, 0);
    wait_strobes(4, 60);
`ifdef IQ_MOD_SAT_EN
    chk("neg64_i", log_i[2], 63);
`else
    chk("neg64_i", log_i[2], -64);
`endif
    chk("neg64_q", log_q[2], 0);
    chk("neg64_cos", log_c[2], 3);
    chk("neg64_uf3", log_uf[3], 1);

    // One-cycle reset with the FIFO full
    chk("mid_uf_pre", 32'(underflow), 1);
    BB_valid = 1'b1; I_BB = 7'(7); Q_BB = 7'(7);
    k = 0;
    while (BB_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("mid_full", 32'(BB_ready), 0);
    reset = 1'b1;
    #1;
    @(negedge clk);
    chk("mid_rst_uf", 32'(underflow), 0);
    chk("mid_rst_i", 32'(I_IF), 0);
    chk("mid_rst_rdy", 32'(DAC_rdy), 0);
    chk("mid_rst_ready", 32'(BB_ready), 0);
    reset = 1'b0; BB_valid = 1'b0;
    #1;
    clear_logs();
    wait_strobes(1, 30);
    chk("mid_t0", log_t[0], 5);
    chk("mid_i0", log_i[0], 0);
    chk("mid_q0", log_q[0], 0);
    chk("mid_cos0", log_c[0], 1);
    chk("mid_uf0", log_uf[0], 1);

    // Push coinciding with a tick while one entry is buffered
    do_reset();
    clear_logs();
    push(12, -3);
    k = 0;
    while (cyc < 4 && k < 10) begin
      @(negedge clk);
      k++;
    end
    push(5, 9);
    chk("tick_push_ready", 32'(BB_ready), 1);
    wait_strobes(3, 40);
    chk("tp_t0", log_t[0], 5);
    chk("tp_i0", log_i[0], 12); chk("tp_q0", log_q[0], -3);
    chk("tp_t1", log_t[1], 10);
    chk("tp_i1", log_i[1], -9); chk("tp_q1", log_q[1], 5);
    chk("tp_uf1", log_uf[1], 0);
    chk("tp_i2", log_i[2], 0);
    chk("tp_uf2", log_uf[2], 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iq_modulation.md
Name: iq_modulation

Overview:
- Transmit-side counterpart of the receive demodulation block (IF → baseband). Takes signed 7-bit baseband I/Q samples and mixes them up to an fs/4 IF using an internal quadrature LO.
- Emits one IF sample pair per DAC strobe on a fixed DAC_DIV-cycle cadence.
- Sits between the baseband pulse-shaping stage and the DAC interface. Buffers up to two samples so upstream jitter does not cause gaps.

Parameters:
- DAC_DIV, 5, clock cycles per DAC sample (≥2); 5 gives 10 MS/s at 50 MHz.
- W, 7, I/Q sample width, two's complement.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- I_BB  in  W  baseband in-phase sample, signed.
- Q_BB  in  W  baseband quadrature sample, signed.
- BB_valid  in  1  I_BB/Q_BB valid.
- BB_ready  out  1  block can accept a sample this cycle.
- I_IF  out  W  IF in-phase output to DAC, signed.
- Q_IF  out  W  IF quadrature output to DAC, signed.
- DAC_rdy  out  1  one-cycle strobe: I_IF/Q_IF hold a new sample.
- cosine_out  out  2  LO cosine used for the current output; +1=01, 0=00, -1=11.
- sine_out  out  2  LO sine used for the current output; same encoding.
- underflow  out  1  sticky: a DAC tick found the buffer empty.

Behaviour:
- Reset (clk edge with reset=1) clears the following; it takes effect mid-operation identically, and buffered samples are discarded.
  - Outputs: I_IF=0, Q_IF=0, DAC_rdy=0, cosine_out=00, sine_out=00, underflow=0, BB_ready=0 during reset.
  - Internal state: FIFO empty, tick counter=0, phase=0.
- Tick counter:
  - Counts 0..DAC_DIV-1 and wraps.
  - Tick cycle = counter at DAC_DIV-1.
  - DAC_rdy is registered and is high in the cycle after each tick cycle, so the first DAC_rdy appears DAC_DIV cycles after reset deasserts. Period is exactly DAC_DIV; duty is one cycle.
- Input FIFO:
  - Depth 2. BB_ready = !reset && FIFO not full.
  - Push on BB_valid && BB_ready. BB_valid while BB_ready=0 is ignored (no drop counted).
  - Pop on every tick cycle with FIFO non-empty.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Accept-to-output latency: a sample pushed into an empty FIFO is emitted at the next tick cycle. DAC_rdy follows 1..DAC_DIV cycles after acceptance.
- LO phase p (2-bit):
  - Advances mod 4 on every tick cycle, whether or not a sample was popped, so the carrier stays coherent.
  - The output produced at a tick uses the pre-increment p.
  - Phase table:
    - p=0: cos=+1, sin=0 → I_IF=I, Q_IF=Q
    - p=1: cos=0, sin=+1 → I_IF=-Q, Q_IF=I
    - p=2: cos=-1, sin=0 → I_IF=-I, Q_IF=-Q
    - p=3: cos=0, sin=-1 → I_IF=Q, Q_IF=-I
  - Mixing is I_IF = I·cos − Q·sin and Q_IF = I·sin + Q·cos. Because every coefficient is 0 or ±1, no multipliers are needed.
- Negation of -64 (-2^(W-1)) is governed by the optional feature below.
- cosine_out/sine_out update together with I_IF/Q_IF.
- Underflow: if the FIFO is empty at a tick, then:
  - I_IF=Q_IF=0 and DAC_rdy still pulses;
  - the phase still advances;
  - underflow is set and is cleared only by reset.
- Between strobes all outputs hold their values.

Optional Feature:
- IQ_MOD_SAT_EN:
  - Defined: negation saturates, so -(-64) = +63.
  - Undefined: plain two's-complement negation, so -(-64) wraps to -64. This is one adder less, and the upstream stage must then guarantee inputs never reach -64.

Test Plan:
- Reset, then idle with BB_valid=0 → DAC_rdy pulses at cycles 5, 10, 15 after reset release; I_IF=Q_IF=0; underflow=1 after the first tick; cosine_out walks 01,00,11,00.
- Stream I=10, Q=-20 continuously → successive strobes give (10,-20), (20,10), (-10,20), (-20,-10), then repeat.
- Hold BB_valid=1 with DAC_DIV=5 → exactly 2 samples accepted before the first tick; BB_ready drops; thereafter 1 sample is accepted per 5 cycles; sample order is preserved.
- I=-64, Q=0 at p=2 → I_IF=+63 with IQ_MOD_SAT_EN, -64 without it; Q_IF=0.
- Assert reset for one cycle with the FIFO full mid-stream → next strobe comes 5 cycles after release, outputs 0, phase restarts at 0, underflow cleared then re-set.
- Push a sample in the same cycle as a tick with 1 entry buffered → buffered entry is emitted, new entry is retained, occupancy stays 1.
